// File: rtl/multi_source_bear_range_sel_pkg.sv
// ============================================================================
// multi_source_bear_range_sel_pkg : register map and shared types for the
// bear/range multi-source selector.                          Revision 1.0
// ============================================================================
`default_nettype none

package multi_source_bear_range_sel_pkg;

   localparam int TMO_RST_DEF = 4000;
   localparam int MAX_SEL_W   = 3;

   // Wide enough for the largest supported source count (8).
   typedef logic [MAX_SEL_W-1:0] sel_t;

   localparam logic [2:0] W_BEAR_SEL = 3'd0;
   localparam logic [2:0] W_SYN_REQ  = 3'd1;
   localparam logic [2:0] W_AUTO_FO  = 3'd2;
   localparam logic [2:0] W_TIMEOUT  = 3'd3;

   localparam logic [2:0] R_CFG0     = 3'd0;
   localparam logic [2:0] R_CFG1     = 3'd1;
   localparam logic [2:0] R_ACTIVE   = 3'd2;
   localparam logic [2:0] R_LOST     = 3'd3;
   localparam logic [2:0] R_BEAR     = 3'd4;
   localparam logic [2:0] R_PERIOD   = 3'd5;
   localparam logic [2:0] R_FO_COUNT = 3'd6;
   localparam logic [2:0] R_ZERO     = 3'd7;

   function automatic sel_t clamp_sel(input logic [31:0] value, input int unsigned num_src);
      if (value >= num_src) return sel_t'(num_src - 1);
      return sel_t'(value);
   endfunction

endpackage

`default_nettype wire

// File: rtl/multi_source_bear_range_sel_synclk_monitor.sv
// ============================================================================
// multi_source_bear_range_sel_synclk_monitor : synchronises one synclk input,
// detects rising edges and flags loss after TIMEOUT idle cycles. Revision 1.0
// ============================================================================
`default_nettype none

module multi_source_bear_range_sel_synclk_monitor
   import multi_source_bear_range_sel_pkg::*;
#(
   parameter int DATA_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              synclk,
   input  logic [DATA_W-1:0] timeout,
   output logic              edge_det,
   output logic              lost
);

   // sync[1:0] is the two-flop synchroniser, sync[2] the previous sample.
   logic [2:0]        sync;
   logic [DATA_W-1:0] idle;
   logic              lost_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync   <= '0;
         idle   <= '0;
         lost_q <= 1'b0;
      end else begin
         sync <= {sync[1:0], synclk};
         if (edge_det)
            idle <= '0;
         else if (idle != '1)
            idle <= idle + 1'b1;
         if (timeout == '0 || edge_det)
            lost_q <= 1'b0;
         else if (idle == timeout)
            lost_q <= 1'b1;
      end
   end

   assign edge_det = sync[1] & ~sync[2];
   // Zero timeout disables detection immediately, not one cycle later.
   assign lost     = lost_q & (timeout != '0);

endmodule

`default_nettype wire

// File: rtl/multi_source_bear_range_sel.sv
// ============================================================================
// multi_source_bear_range_sel : bear word and synclk source selection with
// loss monitoring, glitch-free switching and automatic failover. Revision 1.0
// ============================================================================
`default_nettype none

module multi_source_bear_range_sel
   import multi_source_bear_range_sel_pkg::*;
#(
   parameter  int NUM_SRC = 4,
   parameter  int BEAR_W  = 12,
   parameter  int DATA_W  = 12,
   parameter  int ADDR_W  = 3,
   parameter  int CNT_W   = 8,
   parameter  int TMO_RST = TMO_RST_DEF,
   localparam int SEL_W   = $clog2(NUM_SRC)
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic [ADDR_W-1:0]         WriteAddr,
   input  logic [DATA_W-1:0]         WriteData,
   input  logic                      WriteEnable,
   input  logic [ADDR_W-1:0]         ReadAddr,
   input  logic                      ReadEnable,
   output logic [DATA_W-1:0]         ReadData,
   input  logic [NUM_SRC*BEAR_W-1:0] SrcBear,
   input  logic [NUM_SRC-1:0]        SrcSynclk,
   output logic [BEAR_W-1:0]         BearOut,
   output logic                      SynclkOut,
   output logic [SEL_W-1:0]          ActiveSrc,
   output logic [NUM_SRC-1:0]        LostFlags,
   output logic                      FailoverPulse
);

   logic [SEL_W-1:0]   bear_sel, syn_req, active, active_nxt, live_idx, wr_sel;
   logic               auto_fo;
   logic [DATA_W-1:0]  timeout;
   logic [CNT_W-1:0]   period, period_cnt, period_inc, fo_count;
   logic [NUM_SRC-1:0] edges, lost;
   logic [DATA_W-1:0]  rd_mux;
   logic               wr_bear, wr_syn, wr_fo, wr_tmo;
   logic               fwd, any_live, fo_fire;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_mon
      multi_source_bear_range_sel_synclk_monitor #(
         .DATA_W (DATA_W)
      ) u_mon (
         .clk      (Clk),
         .reset    (Reset),
         .synclk   (SrcSynclk[g]),
         .timeout  (timeout),
         .edge_det (edges[g]),
         .lost     (lost[g])
      );
   end

   assign wr_bear = WriteEnable && (WriteAddr == ADDR_W'(W_BEAR_SEL));
   assign wr_syn  = WriteEnable && (WriteAddr == ADDR_W'(W_SYN_REQ));
   assign wr_fo   = WriteEnable && (WriteAddr == ADDR_W'(W_AUTO_FO));
   assign wr_tmo  = WriteEnable && (WriteAddr == ADDR_W'(W_TIMEOUT));
   assign wr_sel  = SEL_W'(clamp_sel(32'(WriteData), NUM_SRC));

   // Lowest-index source that is still alive.
   always_comb begin
      any_live = 1'b0;
      live_idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (!lost[i]) begin
            any_live = 1'b1;
            live_idx = SEL_W'(i);
         end
      end
   end

   // A software request written this cycle takes priority over failover.
   assign fo_fire = auto_fo && lost[active] && any_live && !wr_syn;

   // Switch only on an edge of the requested source, forwarding that edge alone.
   always_comb begin
      active_nxt = active;
      fwd        = edges[active];
      if (syn_req != active && edges[syn_req]) begin
         active_nxt = syn_req;
         fwd        = 1'b1;
      end
   end

   assign period_inc = (period_cnt == '1) ? period_cnt : period_cnt + 1'b1;

   always_comb begin
      rd_mux = '0;
      case (ReadAddr)
         ADDR_W'(R_CFG0):     rd_mux = DATA_W'(bear_sel);
         ADDR_W'(R_CFG1):     rd_mux = DATA_W'(syn_req);
         ADDR_W'(R_ACTIVE):   rd_mux = DATA_W'(active);
         ADDR_W'(R_LOST):     rd_mux = DATA_W'(lost);
         ADDR_W'(R_BEAR):     rd_mux = DATA_W'(BearOut);
         ADDR_W'(R_PERIOD):   rd_mux = DATA_W'(period);
         ADDR_W'(R_FO_COUNT): rd_mux = DATA_W'(fo_count);
         ADDR_W'(R_ZERO):     rd_mux = '0;
         default:             rd_mux = '0;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         bear_sel      <= '0;
         syn_req       <= '0;
         auto_fo       <= 1'b0;
         timeout       <= DATA_W'(TMO_RST);
         active        <= '0;
         period        <= '0;
         period_cnt    <= '0;
         fo_count      <= '0;
         BearOut       <= '0;
         SynclkOut     <= 1'b0;
         FailoverPulse <= 1'b0;
         ReadData      <= '0;
      end else begin
         if (wr_bear) bear_sel <= wr_sel;
         if (wr_fo)   auto_fo  <= WriteData[0];
         if (wr_tmo)  timeout  <= WriteData;

         BearOut       <= SrcBear[int'(bear_sel)*BEAR_W +: BEAR_W];
         FailoverPulse <= fo_fire;

         if (wr_syn)
            syn_req <= wr_sel;
         else if (fo_fire)
            syn_req <= live_idx;

         if (fo_fire) begin
            active     <= live_idx;
            SynclkOut  <= 1'b0;
            period     <= '0;
            period_cnt <= '0;
            if (fo_count != '1) fo_count <= fo_count + 1'b1;
         end else begin
            active    <= active_nxt;
            SynclkOut <= fwd;
            if (active_nxt != active) begin
               period     <= '0;
               period_cnt <= '0;
            end else if (fwd) begin
               period     <= period_inc;
               period_cnt <= '0;
            end else begin
               period_cnt <= period_inc;
            end
         end

         if (ReadEnable) ReadData <= rd_mux;
      end
   end

   assign ActiveSrc = active;
   assign LostFlags = lost;

endmodule

`default_nettype wire

// File: tb/tb_multi_source_bear_range_sel.sv
// ============================================================================
// tb_multi_source_bear_range_sel : directed register vectors plus hand-built
// switching, failover and loss sequences.                    Revision 1.0
// ============================================================================
`default_nettype none

module tb_multi_source_bear_range_sel;

   localparam int NUM_SRC = 4;
   localparam int BEAR_W  = 12;
   localparam int DATA_W  = 12;
   localparam int ADDR_W  = 3;
   localparam int CNT_W   = 8;
   localparam int SEL_W   = 2;

   logic                      Clk = 1'b0;
   logic                      Reset = 1'b1;
   logic [ADDR_W-1:0]         WriteAddr = '0;
   logic [DATA_W-1:0]         WriteData = '0;
   logic                      WriteEnable = 1'b0;
   logic [ADDR_W-1:0]         ReadAddr = '0;
   logic                      ReadEnable = 1'b0;
   logic [DATA_W-1:0]         ReadData;
   logic [NUM_SRC*BEAR_W-1:0] SrcBear = {12'h3C3, 12'hA5C, 12'h222, 12'h111};
   logic [NUM_SRC-1:0]        SrcSynclk = '0;
   logic [BEAR_W-1:0]         BearOut;
   logic                      SynclkOut;
   logic [SEL_W-1:0]          ActiveSrc;
   logic [NUM_SRC-1:0]        LostFlags;
   logic                      FailoverPulse;

   multi_source_bear_range_sel #(
      .NUM_SRC (NUM_SRC), .BEAR_W (BEAR_W), .DATA_W (DATA_W),
      .ADDR_W  (ADDR_W),  .CNT_W  (CNT_W),  .TMO_RST (4000)
   ) dut (
      .Clk (Clk), .Reset (Reset),
      .WriteAddr (WriteAddr), .WriteData (WriteData), .WriteEnable (WriteEnable),
      .ReadAddr (ReadAddr), .ReadEnable (ReadEnable), .ReadData (ReadData),
      .SrcBear (SrcBear), .SrcSynclk (SrcSynclk), .BearOut (BearOut),
      .SynclkOut (SynclkOut), .ActiveSrc (ActiveSrc), .LostFlags (LostFlags),
      .FailoverPulse (FailoverPulse)
   );

   always #5 Clk = ~Clk;

   // Synclk generator: period 100 cycles, 50% duty, per-source phase offset.
   logic [NUM_SRC-1:0] run = '0;
   int phase [NUM_SRC] = '{0, 37, 0, 0};
   int tcnt = 0;
   always @(negedge Clk) begin
      tcnt++;
      for (int i = 0; i < NUM_SRC; i++)
         if (run[i]) SrcSynclk[i] = (((tcnt + phase[i]) % 100) < 50);
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] addr, input logic [11:0] data);
      @(negedge Clk);
      WriteAddr = addr; WriteData = data; WriteEnable = 1'b1;
      @(posedge Clk); #1;
      WriteEnable = 1'b0;
   endtask

   task automatic rd(input logic [2:0] addr, output logic [11:0] data);
      @(negedge Clk);
      ReadAddr = addr; ReadEnable = 1'b1;
      @(posedge Clk); #1;
      data = ReadData;
      ReadEnable = 1'b0;
   endtask

   typedef struct {
      bit         do_wr;
      logic [2:0] waddr;
      logic [11:0] wdata;
      logic [2:0] raddr;
      logic [11:0] exp;
   } vec_t;

   vec_t tbl [18];

   logic [11:0] got;
   int last, min_gap, fo_seen, fo_cnt;
   bit found, sw_seen, prev;

   initial begin
      tbl[0]  = '{1'b0, 3'd0, 12'h000, 3'd0, 12'h000};
      tbl[1]  = '{1'b0, 3'd0, 12'h000, 3'd1, 12'h000};
      tbl[2]  = '{1'b0, 3'd0, 12'h000, 3'd2, 12'h000};
      tbl[3]  = '{1'b0, 3'd0, 12'h000, 3'd3, 12'h000};
      tbl[4]  = '{1'b0, 3'd0, 12'h000, 3'd4, 12'h111};
      tbl[5]  = '{1'b0, 3'd0, 12'h000, 3'd5, 12'h000};
      tbl[6]  = '{1'b0, 3'd0, 12'h000, 3'd6, 12'h000};
      tbl[7]  = '{1'b0, 3'd0, 12'h000, 3'd7, 12'h000};
      tbl[8]  = '{1'b1, 3'd0, 12'h002, 3'd4, 12'hA5C};
      tbl[9]  = '{1'b1, 3'd0, 12'h007, 3'd0, 12'h003};
      tbl[10] = '{1'b0, 3'd0, 12'h000, 3'd4, 12'h3C3};
      tbl[11] = '{1'b1, 3'd0, 12'h001, 3'd4, 12'h222};
      tbl[12] = '{1'b1, 3'd4, 12'h005, 3'd0, 12'h001};
      tbl[13] = '{1'b1, 3'd7, 12'h000, 3'd0, 12'h001};
      tbl[14] = '{1'b1, 3'd0, 12'h000, 3'd4, 12'h111};
      tbl[15] = '{1'b1, 3'd1, 12'h009, 3'd1, 12'h003};
      tbl[16] = '{1'b1, 3'd1, 12'h000, 3'd1, 12'h000};
      tbl[17] = '{1'b1, 3'd5, 12'h002, 3'd1, 12'h000};

      // Reset and register vectors, all sources idle.
      cycles(2);
      @(negedge Clk); Reset = 1'b0;
      for (int i = 0; i < 18; i++) begin
         if (tbl[i].do_wr) begin
            wr(tbl[i].waddr, tbl[i].wdata);
            cycles(1);
         end
         rd(tbl[i].raddr, got);
         chk($sformatf("vec%0d", i), got, tbl[i].exp);
      end

      // Simultaneous write and read of BEAR_SEL returns the old value.
      @(negedge Clk);
      WriteAddr = 3'd0; WriteData = 12'h002; WriteEnable = 1'b1;
      ReadAddr  = 3'd0; ReadEnable = 1'b1;
      @(posedge Clk); #1;
      WriteEnable = 1'b0; ReadEnable = 1'b0;
      chk("rw_same_cycle", ReadData, 12'h000);
      rd(3'd0, got);
      chk("rw_after", got, 12'h002);

      // BearOut follows a select change one cycle later.
      wr(3'd0, 12'h003);
      chk("bear_lat_old", BearOut, 12'hA5C);
      cycles(1);
      chk("bear_lat_new", BearOut, 12'h3C3);

      // Default timeout: idle sources flag loss around 4000 cycles.
      @(negedge Clk); Reset = 1'b1;
      @(negedge Clk); Reset = 1'b0;
      cycles(3900);
      chk("lost_before_tmo", LostFlags, 4'h0);
      cycles(200);
      chk("lost_after_tmo", LostFlags, 4'hF);
      rd(3'd3, got);
      chk("r3_lost", got, 12'h00F);

      // Run all sources; check +3 latency and 100-cycle period on source 0.
      @(negedge Clk); Reset = 1'b1;
      @(negedge Clk); Reset = 1'b0;
      run = '1;
      prev = SrcSynclk[0];
      found = 1'b0;
      for (int c = 0; c < 300 && !found; c++) begin
         @(posedge Clk);
         if (SrcSynclk[0] && !prev) found = 1'b1;
         prev = SrcSynclk[0];
      end
      chk("src0_rise_seen", found, 1'b1);
      @(posedge Clk); #1;
      chk("lat_cycle2", SynclkOut, 1'b0);
      @(posedge Clk); #1;
      chk("lat_cycle3", SynclkOut, 1'b1);
      cycles(250);
      rd(3'd5, got);
      chk("period_src0", got, 12'd100);
      chk("lost_running", LostFlags, 4'h0);

      // Switch to source 1 (37-cycle phase offset) mid-stream.
      last = -1; min_gap = 1000; sw_seen = 1'b0;
      for (int c = 0; c < 450; c++) begin
         @(posedge Clk); #1;
         if (c == 151) WriteEnable = 1'b0;
         if (SynclkOut) begin
            if (last >= 0 && (c - last) < min_gap) min_gap = c - last;
            last = c;
         end
         if (!sw_seen && ActiveSrc == 2'd1) begin
            sw_seen = 1'b1;
            chk("sw_pulse_at_switch", SynclkOut, 1'b1);
         end
         if (c == 150) begin
            WriteAddr = 3'd1; WriteData = 12'h001; WriteEnable = 1'b1;
         end
      end
      chk("sw_active_seen", sw_seen, 1'b1);
      chk("sw_min_gap_ge37", (min_gap >= 37), 1'b1);
      rd(3'd2, got);
      chk("r2_active1", got, 12'd1);
      rd(3'd5, got);
      chk("period_src1", got, 12'd100);

      // Back to source 0, then failover when it stops.
      wr(3'd1, 12'h000);
      cycles(150);
      chk("back_to_src0", ActiveSrc, 2'd0);
      wr(3'd3, 12'd200);
      wr(3'd2, 12'h001);
      run[0] = 1'b0;
      fo_seen = 0;
      for (int c = 0; c < 600 && fo_seen == 0; c++) begin
         @(posedge Clk); #1;
         if (FailoverPulse) begin
            fo_seen = 1;
            chk("fo_active", ActiveSrc, 2'd1);
            chk("fo_lost0", LostFlags[0], 1'b1);
            @(posedge Clk); #1;
            chk("fo_one_cycle", FailoverPulse, 1'b0);
         end
      end
      chk("fo_seen", fo_seen, 1);
      rd(3'd6, got);
      chk("r6_fo_count", got, 12'd1);
      rd(3'd1, got);
      chk("r1_req_after_fo", got, 12'd1);

      // Stop everything: all lost, no failover, active held.
      run[2] = 1'b0; run[3] = 1'b0;
      fo_cnt = 0; found = 1'b0;
      for (int c = 0; c < 600 && !found; c++) begin
         @(posedge Clk); #1;
         if (FailoverPulse) fo_cnt++;
         if (LostFlags == 4'hD) found = 1'b1;
      end
      chk("lost_2_3", found, 1'b1);
      run[1] = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 600 && !found; c++) begin
         @(posedge Clk); #1;
         if (FailoverPulse) fo_cnt++;
         if (LostFlags == 4'hF) found = 1'b1;
      end
      chk("lost_all", found, 1'b1);
      cycles(5);
      if (FailoverPulse) fo_cnt++;
      chk("no_fo_pulse_all_lost", fo_cnt, 0);
      chk("active_held", ActiveSrc, 2'd1);
      rd(3'd6, got);
      chk("r6_unchanged", got, 12'd1);
      wr(3'd3, 12'd0);
      chk("tmo0_clears", LostFlags, 4'h0);
      cycles(3);
      chk("tmo0_stays", LostFlags, 4'h0);

      // Mid-operation reset.
      run = '1;
      cycles(150);
      @(negedge Clk); Reset = 1'b1;
      @(posedge Clk); #1;
      chk("rst_active", ActiveSrc, 2'd0);
      chk("rst_bear", BearOut, 12'h000);
      chk("rst_readdata", ReadData, 12'h000);
      chk("rst_fo", FailoverPulse, 1'b0);
      chk("rst_synclk", SynclkOut, 1'b0);
      @(negedge Clk); Reset = 1'b0;
      rd(3'd6, got);
      chk("rst_fo_count", got, 12'd0);
      rd(3'd1, got);
      chk("rst_syn_req", got, 12'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
